// File: rtl/ct_ebiu_ncwt_sched.sv
// EBIU non-cacheable write table scheduler: entry allocation, write-order
// dependence, per-entry W/B sequencing and round-robin B return to the PIUs.
module ct_ebiu_ncwt_sched #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned IDX_W     = 3,
  parameter logic [4:0]  WO_EX_ID  = 5'b11110
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             aw_req_vld,
  input  logic [7:0]       aw_req_id,
  input  logic [7:0]       aw_req_tag,
  input  logic             aw_needissue,
  output logic             aw_req_rdy,
  output logic [IDX_W-1:0] aw_alloc_idx,
  input  logic [7:0]       ar_req_tag,
  output logic             ar_depd,
  input  logic             wdata_done_vld,
  input  logic [IDX_W-1:0] wdata_done_idx,
  input  logic             bfifo_vld,
  input  logic [IDX_W-1:0] bfifo_idx,
  input  logic [1:0]       bfifo_bresp,
  output logic             bfifo_pop,
  output logic             b_vld,
  output logic [7:0]       b_id,
  output logic [1:0]       b_resp,
  output logic [3:0]       b_piu_sel,
  input  logic             b_rdy,
  output logic [IDX_W:0]   ncwt_cnt,
  output logic             proto_err
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT_W = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_RESP   = 2'd3
  } ent_st_e;

  ent_st_e              r_st      [ENTRY_NUM];
  ent_st_e              w_st_nxt  [ENTRY_NUM];
  logic [7:0]           r_id      [ENTRY_NUM];
  logic [7:0]           r_tag     [ENTRY_NUM];
  logic [1:0]           r_bresp   [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] r_gm_fail;
  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_perr;

  logic                 w_wo_dep;
  logic                 w_full;
  logic                 w_free_found;
  logic [IDX_W-1:0]     w_alloc_idx;
  logic                 w_alloc;
  logic                 w_gm_fail;
  logic                 w_grant_vld;
  logic [IDX_W-1:0]     w_grant_idx;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_hs;
  logic                 w_perr_set;

  // Tag matching against live entries and lowest-index free-entry search
  always_comb begin
    w_wo_dep     = 1'b0;
    ar_depd      = 1'b0;
    w_free_found = 1'b0;
    w_alloc_idx  = '0;
    for (int i = 0; i < int'(ENTRY_NUM); i++) begin
      if (r_st[i] != ST_FREE) begin
        if (r_tag[i] == aw_req_tag) w_wo_dep = 1'b1;
        if (r_tag[i] == ar_req_tag) ar_depd  = 1'b1;
      end else if (!w_free_found) begin
        w_free_found = 1'b1;
        w_alloc_idx  = IDX_W'(i);
      end
    end
  end

  assign w_full       = (r_cnt == CNT_W'(ENTRY_NUM));
  assign aw_req_rdy   = !w_full && !w_wo_dep;
  assign aw_alloc_idx = w_alloc_idx;
  assign w_alloc      = aw_req_vld && aw_req_rdy;
  assign w_gm_fail    = (aw_req_id[4:0] == WO_EX_ID) && !aw_needissue;

  // Round-robin search over RESP entries starting at the pointer
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < int'(ENTRY_NUM); k++) begin
      w_cand = r_ptr + IDX_W'(k);
      if (!w_grant_vld && (r_st[w_cand] == ST_RESP)) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign b_vld     = w_grant_vld;
  assign b_id      = r_id[w_grant_idx];
  assign b_resp    = r_bresp[w_grant_idx];
  assign b_piu_sel = (4'b0001 << b_id[6:5]) | {4{b_id[7]}};
  assign w_hs      = b_vld && b_rdy;

  // Bus responses are always popped; a stray one only flags the error
  assign bfifo_pop  = bfifo_vld;
  assign w_perr_set = bfifo_vld && (r_st[bfifo_idx] != ST_WAIT_B);

  assign ncwt_cnt  = r_cnt;
  assign proto_err = r_perr;

  // Per-entry next state
  always_comb begin
    for (int i = 0; i < int'(ENTRY_NUM); i++) begin
      w_st_nxt[i] = r_st[i];
      case (r_st[i])
        ST_FREE: begin
          if (w_alloc && (w_alloc_idx == IDX_W'(i))) w_st_nxt[i] = ST_WAIT_W;
        end
        ST_WAIT_W: begin
          if (wdata_done_vld && (wdata_done_idx == IDX_W'(i)))
            w_st_nxt[i] = r_gm_fail[i] ? ST_RESP : ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (bfifo_vld && (bfifo_idx == IDX_W'(i))) w_st_nxt[i] = ST_RESP;
        end
        ST_RESP: begin
          if (w_hs && (w_grant_idx == IDX_W'(i))) w_st_nxt[i] = ST_FREE;
        end
        default: w_st_nxt[i] = ST_FREE;
      endcase
    end
  end

  // State register
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) r_st[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) r_st[i] <= w_st_nxt[i];
    end
  end

  // Entry payload; bresp is zeroed at allocation so a gm-fail entry returns OKAY
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) begin
        r_id[i]    <= '0;
        r_tag[i]   <= '0;
        r_bresp[i] <= '0;
      end
      r_gm_fail <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) begin
        if ((r_st[i] == ST_FREE) && w_alloc && (w_alloc_idx == IDX_W'(i))) begin
          r_id[i]      <= aw_req_id;
          r_tag[i]     <= aw_req_tag;
          r_bresp[i]   <= 2'b00;
          r_gm_fail[i] <= w_gm_fail;
        end else if ((r_st[i] == ST_WAIT_B) && bfifo_vld && (bfifo_idx == IDX_W'(i))) begin
          r_bresp[i] <= bfifo_bresp;
        end
      end
    end
  end

  // Occupancy count, RR pointer and sticky protocol error
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_perr <= 1'b0;
    end else begin
      case ({w_alloc, w_hs})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_hs) r_ptr <= w_grant_idx + IDX_W'(1);
      if (w_perr_set) r_perr <= 1'b1;
    end
  end

endmodule

// File: doc/ct_ebiu_ncwt_sched.md
Name: ct_ebiu_ncwt_sched

Overview:
Scheduler for the EBIU non-cacheable write table (NCWT). It owns ENTRY_NUM write-tracking entries and performs four jobs:
- allocates entries to incoming AW requests;
- enforces write-order address dependence;
- sequences each entry through write-data and bus-response phases;
- round-robin arbitrates the B responses of completed entries back to the requesting PIU(s).

It sits between the NC queue (AW/W issue), the bus B FIFO, and the PIU B-return path.

Parameters:
ENTRY_NUM, 8, number of NCWT entries (power of 2, 2..16)
IDX_W, 3, log2(ENTRY_NUM)
WO_EX_ID, 5'b11110, awid[4:0] encoding marking an exclusive (lock) write

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset, synchronous, active-high
aw_req_vld  in  1  NC queue offers an AW
aw_req_id  in  8  AWID; [7:5]=mid, [4:0]=type
aw_req_tag  in  8  awaddr[13:6]
aw_needissue  in  1  0 = exclusive write failed global monitor (no bus issue)
aw_req_rdy  out  1  AW accepted this cycle when vld&rdy
aw_alloc_idx  out  IDX_W  entry index allocated (valid when vld&rdy)
ar_req_tag  in  8  araddr[13:6]
ar_depd  out  1  read address tag matches a valid entry
wdata_done_vld  in  1  last W beat of an entry sent
wdata_done_idx  in  IDX_W  entry index of that W
bfifo_vld  in  1  bus B response available
bfifo_idx  in  IDX_W  entry index carried by the bus response
bfifo_bresp  in  2  bus BRESP
bfifo_pop  out  1  B FIFO pop (= bfifo_vld, always accepted)
b_vld  out  1  B response to PIU(s)
b_id  out  8  id of returning entry
b_resp  out  2  BRESP
b_piu_sel  out  4  target PIUs: onehot(id[6:5]) OR {4{id[7]}}
b_rdy  in  1  PIU side accepts
ncwt_cnt  out  IDX_W+1  number of non-FREE entries
proto_err  out  1  sticky: B response arrived for an entry not in WAIT_B

Behaviour:
- Per-entry FSM states: FREE, WAIT_W, WAIT_B, RESP.
- Per-entry registers: id[7:0], tag[7:0], bresp[1:0], gm_fail. All entries reset to FREE with zeroed fields.
- Reset values of outputs: aw_req_rdy=1, b_vld=0, ncwt_cnt=0, proto_err=0, RR pointer=0.
- Allocation:
  - aw_req_rdy = !full & !wo_dep. wo_dep is set when aw_req_tag equals the tag of any non-FREE entry.
  - aw_alloc_idx = lowest-index FREE entry.
  - On vld&rdy, the entry takes id/tag and gm_fail = (id[4:0]==WO_EX_ID) & !aw_needissue. It enters WAIT_W next cycle.
  - A non-exclusive write with aw_needissue=0 is treated as a normal write (gm_fail=0).
- ar_depd: combinational tag match against all non-FREE entries.
- WAIT_W -> on wdata_done_vld for this idx:
  - gm_fail=1: go to RESP with bresp=2'b00 (OKAY, no bus response expected).
  - otherwise: go to WAIT_B.
- WAIT_B -> on bfifo_vld for this idx: latch bfifo_bresp and go to RESP.
  - bfifo_vld for an entry in any other state: the response is popped and dropped, proto_err is set, and the entry state is unchanged.
- RESP -> FREE when the entry is granted and b_rdy=1.
- B return arbitration:
  - Round-robin among RESP entries, starting search at the RR pointer.
  - b_vld/b_id/b_resp/b_piu_sel are combinational from the granted entry.
  - On handshake, pointer = granted idx + 1 (wraps modulo ENTRY_NUM).
  - b_vld must hold with a stable grant until b_rdy; the pointer does not move without a handshake.
- Latency:
  - AW accept to WAIT_W: 1 cycle.
  - wdata_done to RESP (gm_fail): 1 cycle; b_vld is visible the following cycle.
  - Bus B to b_vld: 1 cycle after the pop.
- A freed entry becomes allocatable the cycle after its handshake, never in the same cycle.
- Dependence check uses the registered state, so the freeing entry still blocks a same-tag AW in its final cycle.
- Simultaneous events:
  - Allocation, wdata_done, bfifo update and B handshake on different entries in one cycle all take effect.
  - wdata_done and bfifo on the same entry in one cycle: wdata_done applies (entry goes to WAIT_B) and proto_err is set.
- ncwt_cnt: registered count of non-FREE entries; +1 on alloc, -1 on B handshake, net 0 when both occur.
- full = (ncwt_cnt == ENTRY_NUM).
- cpurst asserted mid-operation returns all entries to FREE next edge and clears proto_err; in-flight responses are discarded.

Test Plan:
1. Normal write: AW id=8'h21 tag=8'h10 -> idx0 WAIT_W; wdata_done idx0; bfifo idx0 bresp=2'b00 -> next cycle b_vld=1, b_id=8'h21, b_piu_sel=4'b0010; b_rdy -> ncwt_cnt 1->0.
2. Exclusive gm-fail: AW id=8'h1E, aw_needissue=0; wdata_done -> b_vld with b_resp=2'b00 and no bfifo traffic required; id[7]=0 so b_piu_sel=4'b0001; id 8'h9E -> b_piu_sel=4'b1111.
3. Write-order dependence: entry holding tag 8'h33; new AW tag 8'h33 -> aw_req_rdy=0 until cycle after that entry's B handshake; ar_req_tag=8'h33 -> ar_depd=1 throughout.
4. Full: allocate 8 entries with distinct tags -> ncwt_cnt=8, aw_req_rdy=0; handshake entry 3 together with new AW vld -> AW accepted next cycle into idx3.
5. Round-robin: entries 1, 2, 5 in RESP with pointer 0, b_rdy held 1 -> grants in order 1, 2, 5; with b_rdy=0, b_id stays stable for 5 cycles.
6. Protocol error and reset: bfifo_vld idx4 while idx4 is in WAIT_W -> bfifo_pop=1, proto_err=1, state unchanged; cpurst pulse -> cnt=0, proto_err=0, aw_req_rdy=1.
